// File: rtl/pmod_link_rx.sv
// Pmod link serial receiver: synchronises SCLK/CS_N/MOSI, shifts MSB first, holds words in a valid/ready buffer.
// Word-to-RX_VALID latency is SYNC_STAGES+1 CLK edges; a word completing while the buffer is full and unaccepted sets OVERRUN.
module pmod_link_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCLK,
  input  logic              CS_N,
  input  logic              MOSI,
  input  logic              RX_READY,
  input  logic              CLR_ERR,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              FRAME_ERR,
  output logic              OVERRUN,
  output logic              BUSY,
  output logic [7:0]        FRAME_BYTES
);

  localparam int CNT_W  = $clog2(DATA_W);
  localparam int WARM   = SYNC_STAGES + 2;
  localparam int WARM_W = $clog2(WARM + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sclk_prev_q;
  logic                   sclk_rise_q, cs_rise_q, cs_fall_q, cs_lvl_q, mosi_q;
  logic [WARM_W-1:0]      warm_q;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [7:0]             fbytes_q, fbytes_d;
  logic                   frame_err_q, frame_err_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   overrun_q, overrun_d;

  logic                   cs_s, sclk_s, mosi_s;
  logic                   warm_done, word_done;
  logic [DATA_W-1:0]      word_dat;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == WARM_W'(WARM));
  assign word_dat  = {shift_q[DATA_W-2:0], mosi_q};

  // Edge events are registered so MOSI, SCLK and CS_N events reach the FSM in the same cycle alignment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      sclk_rise_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_lvl_q    <= 1'b1;
      mosi_q      <= 1'b0;
      warm_q      <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_N};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      sclk_rise_q <= sclk_s & ~sclk_prev_q;
      cs_rise_q   <= cs_s & ~cs_prev_q;
      cs_fall_q   <= ~cs_s & cs_prev_q;
      cs_lvl_q    <= cs_s;
      mosi_q      <= mosi_s;
      if (!warm_done) warm_q <= warm_q + WARM_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      fbytes_q    <= '0;
      frame_err_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      fbytes_q    <= fbytes_d;
      frame_err_q <= frame_err_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    fbytes_d    = fbytes_q;
    frame_err_d = 1'b0;
    word_done   = 1'b0;
    case (state_q)
      // Synchroniser reset values are not real samples; wait for them to flush before trusting CS_N.
      WAIT_IDLE: if (warm_done && cs_lvl_q) state_d = IDLE;
      IDLE: begin
        if (cs_fall_q) begin
          bit_cnt_d = '0;
          shift_d   = '0;
          fbytes_d  = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise_q) begin
          shift_d = word_dat;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            word_done = 1'b1;
            if (fbytes_q != 8'hFF) fbytes_d = fbytes_q + 8'd1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        // Uses the post-edge count so a coincident final SCLK edge completes the word cleanly.
        if (cs_rise_q) begin
          frame_err_d = (bit_cnt_d != '0);
          state_d     = IDLE;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (CLR_ERR) overrun_d = 1'b0;
    if (word_done && (!rx_valid_q || RX_READY)) begin
      rx_data_d  = word_dat;
      rx_valid_d = 1'b1;
    end else if (word_done) begin
      overrun_d  = 1'b1;
    end else if (rx_valid_q && RX_READY) begin
      rx_valid_d = 1'b0;
    end
  end

  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;
  assign FRAME_ERR   = frame_err_q;
  assign OVERRUN     = overrun_q;
  assign BUSY        = (state_q == SHIFT);
  assign FRAME_BYTES = fbytes_q;

endmodule

// File: tb/tb_pmod_link_rx.sv
// Directed bench for pmod_link_rx: drives the link at CLK/8 and checks the receive buffer, error flags and counters.
module tb_pmod_link_rx;

  logic       CLK = 1'b0;
  logic       RST, SCLK, CS_N, MOSI, RX_READY, CLR_ERR;
  logic [7:0] RX_DATA;
  logic       RX_VALID, FRAME_ERR, OVERRUN, BUSY;
  logic [7:0] FRAME_BYTES;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int busy_cnt = 0;
  logic [7:0] acc_q[$];

  pmod_link_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI),
    .RX_READY(RX_READY), .CLR_ERR(CLR_ERR), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN),
    .BUSY(BUSY), .FRAME_BYTES(FRAME_BYTES)
  );

  always #5 CLK = ~CLK;

  // Values seen here are the ones the next rising edge acts on.
  always @(negedge CLK) begin
    #1;
    if (FRAME_ERR === 1'b1) fe_cnt++;
    if (BUSY === 1'b1) busy_cnt++;
    if (RX_VALID === 1'b1 && RX_READY === 1'b1) acc_q.push_back(RX_DATA);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    MOSI = b;
    tick(4);
    SCLK = 1'b1;
    tick(4);
    SCLK = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
  endtask

  task automatic cs_low();
    CS_N = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    CS_N = 1'b1;
    tick(8);
  endtask

  task automatic consume();
    RX_READY = 1'b1;
    tick(2);
    RX_READY = 1'b0;
    tick(1);
  endtask

  initial begin
    RST = 1'b1; SCLK = 1'b0; CS_N = 1'b1; MOSI = 1'b0; RX_READY = 1'b0; CLR_ERR = 1'b0;
    tick(3);
    chk("rst_data", RX_DATA, 8'h00);
    chk("rst_valid", RX_VALID, 1'b0);
    chk("rst_ferr", FRAME_ERR, 1'b0);
    chk("rst_ovr", OVERRUN, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_fbytes", FRAME_BYTES, 8'd0);
    RST = 1'b0;
    tick(10);

    // 0xA5, with the last bit timed to measure latency (rise first sampled at next edge k)
    cs_low();
    send_bits(8'hA5, 7);
    MOSI = 1'b1;
    tick(4);
    SCLK = 1'b1;
    tick(3);
    chk("lat_k+2", RX_VALID, 1'b0);
    tick(1);
    chk("lat_k+3", RX_VALID, 1'b1);
    tick(1);
    SCLK = 1'b0;
    cs_high();
    chk("a5_data", RX_DATA, 8'hA5);
    chk("a5_valid", RX_VALID, 1'b1);
    chk("a5_fbytes", FRAME_BYTES, 8'd1);
    chk("a5_no_ferr", fe_cnt, 0);
    chk("a5_idle", BUSY, 1'b0);

    // Three words in one frame, ready held high
    consume();
    chk("a5_consumed", RX_VALID, 1'b0);
    acc_q.delete();
    RX_READY = 1'b1;
    cs_low();
    send_bits(8'h3C, 8);
    send_bits(8'hC3, 8);
    send_bits(8'hFF, 8);
    cs_high();
    RX_READY = 1'b0;
    chk("multi_cnt", acc_q.size(), 3);
    chk("multi_w0", acc_q[0], 8'h3C);
    chk("multi_w1", acc_q[1], 8'hC3);
    chk("multi_w2", acc_q[2], 8'hFF);
    chk("multi_fbytes", FRAME_BYTES, 8'd3);
    chk("multi_ovr", OVERRUN, 1'b0);

    // Overrun, clear, then drain
    acc_q.delete();
    cs_low();
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    cs_high();
    chk("ovr_data", RX_DATA, 8'h11);
    chk("ovr_valid", RX_VALID, 1'b1);
    chk("ovr_flag", OVERRUN, 1'b1);
    chk("ovr_fbytes", FRAME_BYTES, 8'd2);
    CLR_ERR = 1'b1;
    tick(1);
    CLR_ERR = 1'b0;
    tick(1);
    chk("ovr_cleared", OVERRUN, 1'b0);
    consume();
    chk("ovr_drain_valid", RX_VALID, 1'b0);
    chk("ovr_drain_cnt", acc_q.size(), 1);
    chk("ovr_drain_data", acc_q[0], 8'h11);

    // Truncated frame while a word is held
    cs_low();
    send_bits(8'h77, 8);
    cs_high();
    fe_cnt = 0;
    cs_low();
    send_bits(8'hE0, 5);
    cs_high();
    chk("trunc_ferr_cycles", fe_cnt, 1);
    chk("trunc_valid", RX_VALID, 1'b1);
    chk("trunc_data", RX_DATA, 8'h77);
    consume();
    cs_low();
    send_bits(8'h5A, 8);
    cs_high();
    chk("after_trunc_data", RX_DATA, 8'h5A);
    chk("after_trunc_valid", RX_VALID, 1'b1);
    chk("after_trunc_fbytes", FRAME_BYTES, 8'd1);

    // Reset mid-frame; the in-progress frame must be ignored
    consume();
    cs_low();
    send_bits(8'hF0, 3);
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    busy_cnt = 0;
    send_bits(8'hFF, 8);
    chk("midrst_busy_cycles", busy_cnt, 0);
    chk("midrst_valid", RX_VALID, 1'b0);
    cs_high();
    cs_low();
    send_bits(8'h81, 8);
    cs_high();
    chk("midrst_data", RX_DATA, 8'h81);
    chk("midrst_valid2", RX_VALID, 1'b1);

    // Completion coincident with accept of the held 0x81
    acc_q.delete();
    cs_low();
    send_bits(8'h42, 7);
    MOSI = 1'b0;
    tick(4);
    SCLK = 1'b1;
    tick(3);
    RX_READY = 1'b1;
    tick(1);
    RX_READY = 1'b0;
    chk("coinc_valid", RX_VALID, 1'b1);
    chk("coinc_data", RX_DATA, 8'h42);
    chk("coinc_ovr", OVERRUN, 1'b0);
    chk("coinc_acc_cnt", acc_q.size(), 1);
    chk("coinc_acc_data", acc_q[0], 8'h81);
    tick(1);
    SCLK = 1'b0;
    cs_high();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmod_link_rx.md
Name: pmod_link_rx

Overview:
- Serial byte receiver for the Pmod header link. It is the receiving end of the 3-wire link (SCLK, CS_N, MOSI) that a peer board drives out of its Jx connector.
- Synchronises the pin signals into the CLK domain, shifts bits MSB first on SCLK rising edges, and presents each completed byte through a valid/ready holding buffer.
- Flags truncated frames and overruns to the consuming logic (for example the task_B-style control logic in Top_Student).

Parameters:
- DATA_W, 8, bits per received word.
- SYNC_STAGES, 2, flip-flop stages in each pin synchroniser (minimum 2).

Ports:
- CLK  input  1  system clock. Link SCLK must be at most CLK/8.
- RST  input  1  asynchronous active-high reset.
- SCLK  input  1  link serial clock, idle low (mode 0).
- CS_N  input  1  link frame select, active low.
- MOSI  input  1  link serial data.
- RX_READY  input  1  consumer accepts RX_DATA this cycle.
- CLR_ERR  input  1  clears OVERRUN.
- RX_DATA  output  DATA_W  held received word.
- RX_VALID  output  1  RX_DATA holds an unconsumed word.
- FRAME_ERR  output  1  one-cycle pulse: frame ended mid-word.
- OVERRUN  output  1  sticky: a completed word was dropped.
- BUSY  output  1  high while in SHIFT state.
- FRAME_BYTES  output  8  count of words completed in the current or most recent frame; saturates at 255.

Behaviour:
- Reset (async, RST=1):
  - Outputs: RX_DATA=0, RX_VALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0, FRAME_BYTES=0.
  - Internal: shift register=0, bit counter=0, state=WAIT_IDLE.
  - Synchroniser reset values: CS_N chain=1, SCLK chain=0, MOSI chain=0.
- Synchronisation and edge detection:
  - Each pin passes through SYNC_STAGES flops.
  - The SCLK rising edge and CS_N falling/rising edges are detected by comparing the last synchroniser stage with one extra registered copy.
- States:
  - WAIT_IDLE: wait for synced CS_N=1, then go to IDLE. A frame already in progress at reset release is ignored.
  - IDLE: on a CS_N falling edge, clear bit counter, shift register and FRAME_BYTES, then go to SHIFT.
  - SHIFT: BUSY=1. On each SCLK rising edge, shift = {shift[DATA_W-2:0], MOSI_sync} and the bit counter increments.
- Word completion (DATA_W-th rising edge): the completed word is offered to the holding buffer in the same cycle, the bit counter returns to 0, FRAME_BYTES increments, and the state stays in SHIFT. Multiple words per frame are allowed.
- Frame end (CS_N rising edge in SHIFT):
  - If the bit counter is not 0: FRAME_ERR pulses for 1 cycle and the partial word is discarded.
  - If the bit counter is 0: silent.
  - Either way, go to IDLE.
  - A CS_N rise coincident with the last SCLK edge completes the word first, with no FRAME_ERR.
- Holding buffer:
  - Accept occurs when RX_VALID and RX_READY are both 1 at a clock edge; RX_VALID clears unless a new word loads in the same cycle.
  - Completion with the buffer empty, or coincident with an accept: load RX_DATA, RX_VALID=1, no overrun.
  - Completion while RX_VALID=1 and RX_READY=0: the new word is dropped, RX_DATA is unchanged, OVERRUN is set.
  - OVERRUN clears only on CLR_ERR=1 or reset. If set and clear coincide, set wins.
- Latency: if the pin SCLK edge completing a word is first sampled at CLK edge k, RX_VALID is 1 after edge k+SYNC_STAGES+1.
- CS_N glitches in IDLE shorter than one CLK period may be missed. No requirement applies to them.

Test Plan:
- Reset then CS_N low; send 0xA5 MSB first at CLK/8; CS_N high; RX_READY=0 -> RX_DATA=0xA5, RX_VALID=1, FRAME_BYTES=1, FRAME_ERR never asserted.
- One frame carrying 0x3C, 0xC3, 0xFF with RX_READY=1 throughout -> three single-cycle valid/accept handshakes in that order, FRAME_BYTES=3, OVERRUN=0.
- Send 0x11 and 0x22 with RX_READY=0 -> RX_DATA stays 0x11 and OVERRUN=1. Pulse CLR_ERR -> OVERRUN=0. Raise RX_READY -> 0x11 is consumed, RX_VALID=0.
- CS_N low, 5 SCLK edges, then CS_N high -> FRAME_ERR high for exactly 1 cycle, RX_VALID unchanged. Next full frame 0x5A is received correctly.
- Assert RST with CS_N low mid-frame, release while CS_N still low and keep clocking -> no word and BUSY=0 until CS_N goes high then low again. The subsequent 0x81 is received correctly.
- Deliver the completing SCLK edge in the same CLK cycle that RX_READY accepts the previous word -> the new word loads, RX_VALID stays 1, OVERRUN=0.
